// File: rtl/uart_rx_pattern_trigger.sv
// Byte-stream consumer behind uart_core's receive handshake: keeps a history of
// recent bytes and pulses trigger when a programmable masked pattern matches.
`timescale 1ns/1ps
module uart_rx_pattern_trigger #(
  parameter int pMAX_BYTES = 8,
  parameter int pCOUNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    arm,
  input  logic                    single_shot,
  input  logic [3:0]              pattern_len,
  input  logic [8*pMAX_BYTES-1:0] pattern,
  input  logic [8*pMAX_BYTES-1:0] pattern_mask,
  input  logic                    rxd_syn,
  input  logic [7:0]              rxd_data,
  output logic                    rxd_ack,
  output logic                    trigger,
  output logic [pCOUNT_W-1:0]     match_count,
  output logic                    fired
);

  localparam int CNT_W = $clog2(pMAX_BYTES + 1);

  typedef enum logic [0:0] {
    WAIT_SYN = 1'b0,
    ACK      = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic                    cap_s;
  logic                    ack_next_s;
  logic                    cap_r;
  logic                    rxd_ack_r;
  logic [8*pMAX_BYTES-1:0] hist_r;
  logic [8*pMAX_BYTES-1:0] hist_next_s;
  logic [CNT_W-1:0]        valid_cnt_r;
  logic [31:0]             eff_len_s;
  logic                    match_s;
  logic                    issue_s;
  logic                    trigger_r;
  logic                    fired_r;
  logic [pCOUNT_W-1:0]     match_count_r;

  // Byte i of the history matches when every enabled bit equals the pattern bit.
  function automatic logic masked_match(
    input logic [8*pMAX_BYTES-1:0] hist,
    input logic [8*pMAX_BYTES-1:0] pat,
    input logic [8*pMAX_BYTES-1:0] mask,
    input logic [31:0]             len
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < pMAX_BYTES; i++) begin
      if ((32'(i) < len) && (((hist[8*i +: 8] ^ pat[8*i +: 8]) & mask[8*i +: 8]) != 8'h00)) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // Handshake state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= WAIT_SYN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Handshake next-state logic.
  always_comb begin
    next_state_s = WAIT_SYN;
    case (state_r)
      WAIT_SYN: next_state_s = rxd_syn ? ACK : WAIT_SYN;
      ACK:      next_state_s = rxd_syn ? ACK : WAIT_SYN;
      default:  next_state_s = WAIT_SYN;
    endcase
  end

  // Handshake outputs: capture only on the WAIT_SYN edge, ack follows the state.
  always_comb begin
    cap_s      = 1'b0;
    ack_next_s = 1'b0;
    case (state_r)
      WAIT_SYN: begin
        cap_s      = rxd_syn;
        ack_next_s = rxd_syn;
      end
      ACK: begin
        cap_s      = 1'b0;
        ack_next_s = rxd_syn;
      end
      default: begin
        cap_s      = 1'b0;
        ack_next_s = 1'b0;
      end
    endcase
  end

  // Next history: older bytes move up one slot, the new byte lands in slot 0.
  always_comb begin
    hist_next_s        = hist_r;
    hist_next_s[7:0]   = rxd_data;
    for (int i = 1; i < pMAX_BYTES; i++) begin
      hist_next_s[8*i +: 8] = hist_r[8*(i-1) +: 8];
    end
  end

  // Compare on the edge after capture, with config sampled here.
  always_comb begin
    eff_len_s = (32'(pattern_len) > 32'(pMAX_BYTES)) ? 32'(pMAX_BYTES) : 32'(pattern_len);
    match_s   = cap_r && (eff_len_s != 32'd0) && (32'(valid_cnt_r) >= eff_len_s) &&
                masked_match(hist_r, pattern, pattern_mask, eff_len_s);
    issue_s   = match_s && arm && !(single_shot && fired_r);
  end

  // Ack and capture strobe registers; clear drops a byte captured on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_ack_r <= 1'b0;
      cap_r     <= 1'b0;
    end else begin
      rxd_ack_r <= ack_next_s;
      cap_r     <= cap_s && !clear;
    end
  end

  // History and fill level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_r      <= '0;
      valid_cnt_r <= '0;
    end else if (clear) begin
      hist_r      <= '0;
      valid_cnt_r <= '0;
    end else if (cap_s) begin
      hist_r      <= hist_next_s;
      valid_cnt_r <= (valid_cnt_r != CNT_W'(pMAX_BYTES)) ? valid_cnt_r + CNT_W'(1) : valid_cnt_r;
    end else begin
      hist_r      <= hist_r;
      valid_cnt_r <= valid_cnt_r;
    end
  end

  // Match counter, trigger pulse and single-shot flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_count_r <= '0;
      trigger_r     <= 1'b0;
      fired_r       <= 1'b0;
    end else if (clear) begin
      match_count_r <= '0;
      trigger_r     <= 1'b0;
      fired_r       <= 1'b0;
    end else begin
      if (match_s && (match_count_r != {pCOUNT_W{1'b1}})) begin
        match_count_r <= match_count_r + pCOUNT_W'(1);
      end else begin
        match_count_r <= match_count_r;
      end
      trigger_r <= issue_s;
      if (!arm) begin
        fired_r <= 1'b0;
      end else if (issue_s && single_shot) begin
        fired_r <= 1'b1;
      end else begin
        fired_r <= fired_r;
      end
    end
  end

  assign rxd_ack     = rxd_ack_r;
  assign trigger     = trigger_r;
  assign match_count = match_count_r;
  assign fired       = fired_r;

endmodule

// File: tb/tb_uart_rx_pattern_trigger.sv
// Self-checking bench: directed scenarios plus random byte streams compared
// against a queue-based reference model of the pattern trigger.
`timescale 1ns/1ps
module tb_uart_rx_pattern_trigger;
  localparam int MAXB = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            clear = 1'b0;
  logic            arm = 1'b0;
  logic            single_shot = 1'b0;
  logic [3:0]      pattern_len = 4'd0;
  logic [8*MAXB-1:0] pattern = '0;
  logic [8*MAXB-1:0] pattern_mask = '0;
  logic            rxd_syn = 1'b0;
  logic [7:0]      rxd_data = 8'h00;
  logic            rxd_ack;
  logic            trigger;
  logic [15:0]     match_count;
  logic            fired;

  int checks = 0;
  int failures = 0;
  int trig_seen = 0;
  int trig_exp = 0;

  // reference model state: newest byte at index 0
  logic [7:0] hist_q[$];
  int         m_count = 0;
  bit         m_fired = 1'b0;

  uart_rx_pattern_trigger #(.pMAX_BYTES(MAXB), .pCOUNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .arm(arm), .single_shot(single_shot),
    .pattern_len(pattern_len), .pattern(pattern), .pattern_mask(pattern_mask),
    .rxd_syn(rxd_syn), .rxd_data(rxd_data), .rxd_ack(rxd_ack), .trigger(trigger),
    .match_count(match_count), .fired(fired)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (trigger === 1'b1) trig_seen++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    hist_q.delete();
    m_count = 0;
    m_fired = 1'b0;
  endfunction

  // One captured byte followed by its compare, using the config currently driven.
  task automatic model_cap(input logic [7:0] b, input bit clr, output bit t);
    int  len;
    bit  m;
    t = 1'b0;
    if (clr) begin
      model_reset();
      return;
    end
    hist_q.push_front(b);
    if (hist_q.size() > MAXB) void'(hist_q.pop_back());
    len = (int'(pattern_len) > MAXB) ? MAXB : int'(pattern_len);
    m = (len != 0) && (hist_q.size() >= len);
    for (int i = 0; i < len && m; i++)
      if (((hist_q[i] ^ pattern[8*i +: 8]) & pattern_mask[8*i +: 8]) != 8'h00) m = 1'b0;
    if (m) begin
      if (m_count < 65535) m_count++;
      if (arm && !(single_shot && m_fired)) begin
        t = 1'b1;
        if (single_shot) m_fired = 1'b1;
      end
    end
    if (!arm) m_fired = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit clr);
    bit t;
    int n;
    rxd_data = b;
    rxd_syn  = 1'b1;
    clear    = clr;
    @(negedge clk);
    clear = 1'b0;
    n = 0;
    while (rxd_ack !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ack_rise", rxd_ack, 1);
    model_cap(b, clr, t);
    trig_exp += t;
    rxd_syn = 1'b0;
    @(negedge clk);
    check("trigger", trigger, t);
    check("ack_fall", rxd_ack, 0);
    check("match_count", match_count, m_count);
    check("fired", fired, m_fired);
  endtask

  task automatic set_arm(input logic v);
    arm = v;
    @(negedge clk);
    if (!v) m_fired = 1'b0;
    check("fired_arm", fired, m_fired);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    check("clear_count", match_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] alpha [3];
    alpha[0] = 8'h41; alpha[1] = 8'h42; alpha[2] = 8'h43;
    pattern_mask = {MAXB{8'hFF}};
    #12;
    check("reset_ack", rxd_ack, 0);
    check("reset_trigger", trigger, 0);
    check("reset_count", match_count, 0);
    check("reset_fired", fired, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: long syn, single capture
    pattern_len = 4'd1; pattern = 64'h41; arm = 1'b1;
    rxd_data = 8'h41; rxd_syn = 1'b1;
    @(negedge clk);
    check("hs_ack_rise", rxd_ack, 1);
    @(negedge clk);
    check("hs_trigger", trigger, 1);
    trig_exp++;
    repeat (3) @(negedge clk);
    check("hs_ack_held", rxd_ack, 1);
    check("hs_trigger_once", trigger, 0);
    rxd_syn = 1'b0;
    @(negedge clk);
    check("hs_ack_fall", rxd_ack, 0);
    check("hs_one_capture", match_count, 1);

    // 2: "ABC" with len 3
    do_clear();
    pattern_len = 4'd3; pattern = 64'h41_42_43;
    send_byte(8'h41, 0); send_byte(8'h42, 0); send_byte(8'h43, 0);
    check("abc_count", match_count, 1);

    // 3: single shot
    do_clear();
    single_shot = 1'b1;
    send_byte(8'h41, 0); send_byte(8'h42, 0); send_byte(8'h43, 0);
    send_byte(8'h41, 0); send_byte(8'h42, 0); send_byte(8'h43, 0);
    check("ss_count", match_count, 2);
    check("ss_fired", fired, 1);
    set_arm(1'b0);
    set_arm(1'b1);
    send_byte(8'h41, 0); send_byte(8'h42, 0); send_byte(8'h43, 0);
    check("ss_rearm_fired", fired, 1);
    single_shot = 1'b0;

    // 4: masked nibble compare
    do_clear();
    pattern_len = 4'd1; pattern = 64'h30; pattern_mask = 64'hF0;
    send_byte(8'h35, 0); send_byte(8'h3F, 0); send_byte(8'h45, 0);
    check("mask_count", match_count, 2);

    // 5: insufficient history, then clear on the capture
    do_reset();
    pattern_len = 4'd4; pattern = 64'h41_42_43_44; pattern_mask = {MAXB{8'hFF}};
    send_byte(8'h41, 0); send_byte(8'h42, 0); send_byte(8'h43, 0);
    send_byte(8'h44, 1);
    check("clr_count", match_count, 0);

    // 6: async reset mid-handshake
    pattern_len = 4'd1; pattern = 64'h55;
    send_byte(8'h55, 0);
    rxd_data = 8'h55; rxd_syn = 1'b1;
    @(negedge clk);
    check("rst_pre_ack", rxd_ack, 1);
    check("rst_pre_count", match_count, 2'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_async_ack", rxd_ack, 0);
    check("rst_async_trigger", trigger, 0);
    check("rst_async_count", match_count, 0);
    rxd_syn = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    send_byte(8'h55, 0);
    check("rst_after_count", match_count, 1);

    // random streams over a small alphabet with random configs
    for (int blk = 0; blk < 8; blk++) begin
      pattern_len = 4'($urandom_range(0, 10));
      for (int i = 0; i < MAXB; i++) begin
        pattern[8*i +: 8]      = alpha[$urandom_range(0, 2)];
        pattern_mask[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      end
      if (blk >= 4) pattern_len = 4'($urandom_range(1, 3));
      single_shot = 1'($urandom);
      for (int j = 0; j < 40; j++) begin
        if ($urandom_range(0, 9) == 0) set_arm(~arm);
        send_byte(alpha[$urandom_range(0, 2)], $urandom_range(0, 29) == 0);
      end
    end

    check("trigger_pulses", trig_seen, trig_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
